bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the seven-segment decoders on the display path. It takes an unsigned binary value, for example a register or PC value from the pipelined computer. It produces NDIG registered 4-bit digit codes, each of which drives one decoder instance. Leading zeros are optionally replaced by the blank code 4'hF, which the decoder renders as all segments off.

Parameters:
WIDTH, 16, bit width of the binary input.
NDIG, 5, number of BCD digits produced. 5 covers 16 bits.
BLANK_LZ, 1, when 1, leading-zero digits are output as 4'hF.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_value is valid this cycle.
in_ready  output  1  converter can accept a value. Equals (state == IDLE).
in_value  input  WIDTH  unsigned binary value to convert.
out_valid  output  1  one-cycle pulse; digits updated this cycle.
digits  output  4*NDIG  digit codes. Digit 0 (units) is in bits [3:0]; digit i is in bits [4i+3:4i].
busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; shift/count scratch registers = 0.
  - digits = all 4'hF (display dark); out_valid = 0.
  - in_ready = 1 and busy = 0 while reset is held.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - A handshake occurs on in_valid && in_ready at a rising edge (edge E0).
  - At E0: capture in_value into the binary shift register, clear the BCD scratch register (4*NDIG bits), load count = WIDTH, go to SHIFT.
  - With no handshake, stay in IDLE.
- SHIFT, one iteration per edge (E1..E_WIDTH):
  - Step 1: each BCD digit >= 5 gets +3.
  - Step 2: shift the concatenation {bcd, bin} left by 1; the bin MSB enters the bcd LSB.
  - Step 3: decrement count. When count reaches 1 at an edge, that edge performs the last iteration and moves to DONE.
- DONE (edge E_WIDTH+1):
  - Load digits from the BCD scratch, applying blanking.
  - Pulse out_valid high for exactly the following cycle; return to IDLE.
- Latency and throughput:
  - out_valid is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+2 cycles after acceptance (18 for WIDTH=16).
  - Next acceptance is possible at edge E_WIDTH+2, giving throughput of one conversion per WIDTH+2 cycles.
- digits is held constant between DONE updates, so there is no flicker during a conversion.
- Blanking (BLANK_LZ=1):
  - Scan from digit NDIG-1 downward; every 0 before the first non-zero digit becomes 4'hF.
  - Digit 0 is never blanked, so value 0 displays "0".
  - With BLANK_LZ=0, digits carry raw BCD.
- Width rule: carries out of the top digit are discarded, so the result equals in_value mod 10^NDIG. No overflow flag.
- Inputs outside IDLE: in_valid is ignored in SHIFT and DONE and has no effect on in_value capture. Upstream must hold in_value and in_valid until in_ready.
- Reset mid-conversion: aborts immediately, with all outputs at their reset values. No out_valid is produced for the aborted value.
- out_valid never asserts without a preceding handshake.

Decomposition:
- Shared package holds:
  - DIGIT_BLANK = 4'hF.
  - State encoding localparams for IDLE, SHIFT, DONE.
  - Helper function giving the minimum NDIG for a WIDTH, used by integrators.
- One sub-module, bcd_adjust: purely combinational; 4-bit digit in, digit+3 if >= 5 else unchanged. Instantiated NDIG times inside the SHIFT datapath.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> digits=20'hFFFFF, out_valid=0, in_ready=1, busy=0 immediately.
- Zero and max (WIDTH=16, NDIG=5, BLANK_LZ=1): convert 0 -> digits=20'hFFFF0, out_valid exactly 18 cycles after acceptance. Convert 65535 -> digits=20'h65535.
- Blanking: convert 1234 -> 20'hF1234. Repeat with BLANK_LZ=0 -> 20'h01234.
- Back-to-back: hold in_valid high with 42, then 7.
  - Required: in_ready low for 17 cycles after acceptance.
  - Required: digits stays 20'hFFF42 during the second conversion, then becomes 20'hFFFF7.
  - Required: exactly two out_valid pulses.
- Reset mid-conversion: accept 9999, assert reset at E5 -> state IDLE, digits=20'hFFFFF, no out_valid. A new request for 5 afterward -> 20'hFFFF5.
- Truncation (WIDTH=8, NDIG=2): convert 255 -> digits=8'h55 after 10 cycles. Convert 99 -> 8'h99.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: blank code,
// FSM encoding and a sizing helper for integrators.
package bin2bcd_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_e;

  // Smallest digit count that shows every value of a WIDTH-bit unsigned input.
  function automatic int min_ndig(input int width);
    longint unsigned maxv;
    longint unsigned p;
    int n;
    maxv = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    p = 64'd10;
    n = 1;
    for (int k = 0; k < 19; k++) begin
      if (p <= maxv) begin
        n = n + 1;
        p = p * 64'd10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decade.
module bcd_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with registered digit outputs and optional leading-zero blanking.
//
// Handshake: a value is accepted on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, and upstream holds in_value/in_valid until then.
// out_valid is a single-cycle pulse in the cycle the new digits first appear.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NDIG     = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_value,
  output logic                out_valid,
  output logic [4*NDIG-1:0]   digits,
  output logic                busy,
  output state_e              dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e              state_q;
  logic [WIDTH-1:0]    bin_q;
  logic [4*NDIG-1:0]   bcd_q;
  logic [CW-1:0]       count_q;
  logic [4*NDIG-1:0]   digits_q;
  logic                out_valid_q;

  logic [4*NDIG-1:0]   adj_bcd;
  logic [WIDTH-1:0]    bin_d;
  logic [4*NDIG-1:0]   bcd_d;
  logic [4*NDIG-1:0]   blanked;
  logic                lead;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adjust u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (adj_bcd[4*g +: 4])
    );
  end

  // Carry out of the top digit falls off the end, giving value mod 10^NDIG.
  always_comb begin
    {bcd_d, bin_d} = {adj_bcd, bin_q} << 1;
  end

  always_comb begin
    blanked = bcd_q;
    lead    = (BLANK_LZ != 0);
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'd0)) begin
        blanked[4*i +: 4] = DIGIT_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      count_q     <= '0;
      digits_q    <= {NDIG{DIGIT_BLANK}};
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            bin_q   <= in_value;
            bcd_q   <= '0;
            count_q <= CW'(WIDTH);
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q   <= bcd_d;
          bin_q   <= bin_d;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          digits_q    <= blanked;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign digits    = digits_q;
  assign dbg_state = state_q;

endmodule
